// File: rtl/memory_types_pkg.sv
// Shared types for the memory arbiter: arbiter state encoding, memory word
// type and the sizing rule for the starvation counter.
package memory_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Grant owner of the single memory port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    // Counter width able to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((max_val >> w) != 0) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating count of data grants taken while an instruction fetch waits.
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   inc            count one data grant (ignored once saturated)
//   clr            return to zero; wins over inc
//   at_max         count equals MAX_VAL
//   cnt            current count
module starve_counter
    import memory_types_pkg::*;
#(
    parameter int unsigned MAX_VAL = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             clr,
    output logic             at_max,
    output logic [CNT_W-1:0] cnt
);

    assign at_max = (cnt == CNT_W'(MAX_VAL));

    // Saturating up-counter with priority clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates the instruction-fetch port and the data load/store port onto a
// single-ported memory. Data wins by default; after STARVE_MAX consecutive
// data grants with a fetch pending, the fetch is granted next.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   iREN, iaddr                   fetch request and address
//   dREN, dWEN, daddr, dstore     data read/write request, address, write data
//   iwait, dwait                  access not yet complete (combinational)
//   iload, dload                  read data, straight from ramload
//   ramREN, ramWEN, ramaddr,
//   ramstore                      memory command, registered
//   ramload, ram_ready            memory read data and completion pulse
module memory_arbiter
    import memory_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [DATA_W-1:0] iload,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready
);

    localparam int unsigned SCNT_W = cnt_width(STARVE_MAX);

    arb_state_t        state;
    arb_state_t        next_state;
    logic [SCNT_W-1:0] scnt;
    logic              scnt_inc;
    logic              scnt_clr;
    logic              scnt_at_max;
    logic              data_req;

    logic              ren_nxt;
    logic              wen_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] store_nxt;

    assign data_req = dREN | dWEN;

    starve_counter #(
        .MAX_VAL (STARVE_MAX),
        .CNT_W   (SCNT_W)
    ) u_starve (
        .CLK     (CLK),
        .RST     (RST),
        .inc     (scnt_inc),
        .clr     (scnt_clr),
        .at_max  (scnt_at_max),
        .cnt     (scnt)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, counter control and the memory command for the next cycle.
    always_comb begin
        next_state = state;
        scnt_inc   = 1'b0;
        scnt_clr   = 1'b0;
        ren_nxt    = 1'b0;
        wen_nxt    = 1'b0;
        addr_nxt   = '0;
        store_nxt  = '0;

        case (state)
            IDLE: begin
                // A saturated counter with a fetch pending hands the port to
                // the fetch; with STARVE_MAX=0 this is always the case.
                if (data_req && !(iREN && scnt_at_max)) begin
                    next_state = DATA;
                    scnt_inc   = iREN;
                end else if (iREN) begin
                    next_state = INSTR;
                    scnt_clr   = 1'b1;
                end
            end
            // Completion or a withdrawn request both end the grant.
            INSTR: begin
                if (ram_ready || !iREN) begin
                    next_state = IDLE;
                end
            end
            DATA: begin
                if (ram_ready || !data_req) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        case (next_state)
            INSTR: begin
                ren_nxt  = 1'b1;
                addr_nxt = iaddr;
            end
            DATA: begin
                // Write takes precedence when both enables are raised.
                wen_nxt   = dWEN;
                ren_nxt   = dREN & ~dWEN;
                addr_nxt  = daddr;
                store_nxt = dstore;
            end
            default: begin
                ren_nxt = 1'b0;
            end
        endcase
    end

    // Memory command register; requesters hold address/data stable while
    // their request is up, so the registered copy tracks the live inputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
        end else begin
            ramREN   <= ren_nxt;
            ramWEN   <= wen_nxt;
            ramaddr  <= addr_nxt;
            ramstore <= store_nxt;
        end
    end

    // Waits drop in the very cycle the memory completes.
    assign iwait = iREN & ~((state == INSTR) & ram_ready);
    assign dwait = data_req & ~((state == DATA) & ram_ready);

    assign iload = ramload;
    assign dload = ramload;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: three instances (STARVE_MAX 4, 2, 0) share the
// stimulus; each scenario observes the instance it targets.
module tb_memory_arbiter;
    import memory_types_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic          instr;
        logic          ren;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] store;
        logic [3:0]    scnt;
        logic          done;
    } grant_t;

    logic          CLK;
    logic          RST;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic [DW-1:0] ramload;
    logic          ram_ready;

    logic          iwait_v    [3];
    logic          dwait_v    [3];
    logic [DW-1:0] iload_v    [3];
    logic [DW-1:0] dload_v    [3];
    logic          ramREN_v   [3];
    logic          ramWEN_v   [3];
    logic [AW-1:0] ramaddr_v  [3];
    logic [DW-1:0] ramstore_v [3];

    int n_cmp;
    int n_fail;

    grant_t exp_q[$];
    grant_t got_q[$];

    logic          obs_ren;
    logic          obs_wen;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_store;
    logic          obs_iwait;
    logic          obs_dwait;
    logic [DW-1:0] obs_iload;
    arb_state_t    obs_state;
    logic [3:0]    obs_scnt;

    memory_arbiter #(.STARVE_MAX(4), .ADDR_W(AW), .DATA_W(DW)) dut_s4 (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait_v[0]), .dwait(dwait_v[0]),
        .iload(iload_v[0]), .dload(dload_v[0]), .ramREN(ramREN_v[0]), .ramWEN(ramWEN_v[0]),
        .ramaddr(ramaddr_v[0]), .ramstore(ramstore_v[0]), .ramload(ramload), .ram_ready(ram_ready)
    );

    memory_arbiter #(.STARVE_MAX(2), .ADDR_W(AW), .DATA_W(DW)) dut_s2 (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait_v[1]), .dwait(dwait_v[1]),
        .iload(iload_v[1]), .dload(dload_v[1]), .ramREN(ramREN_v[1]), .ramWEN(ramWEN_v[1]),
        .ramaddr(ramaddr_v[1]), .ramstore(ramstore_v[1]), .ramload(ramload), .ram_ready(ram_ready)
    );

    memory_arbiter #(.STARVE_MAX(0), .ADDR_W(AW), .DATA_W(DW)) dut_s0 (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait_v[2]), .dwait(dwait_v[2]),
        .iload(iload_v[2]), .dload(dload_v[2]), .ramREN(ramREN_v[2]), .ramWEN(ramWEN_v[2]),
        .ramaddr(ramaddr_v[2]), .ramstore(ramstore_v[2]), .ramload(ramload), .ram_ready(ram_ready)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // Copy the selected instance's outputs into the obs_* variables.
    task automatic sample(input int sel);
        obs_ren   = ramREN_v[sel];
        obs_wen   = ramWEN_v[sel];
        obs_addr  = ramaddr_v[sel];
        obs_store = ramstore_v[sel];
        obs_iwait = iwait_v[sel];
        obs_dwait = dwait_v[sel];
        obs_iload = iload_v[sel];
        case (sel)
            0:       begin obs_state = dut_s4.state; obs_scnt = 4'(dut_s4.scnt); end
            1:       begin obs_state = dut_s2.state; obs_scnt = 4'(dut_s2.scnt); end
            default: begin obs_state = dut_s0.state; obs_scnt = 4'(dut_s0.scnt); end
        endcase
    endtask

    // One-cycle reset pulse; returns just after the edge that released it.
    task automatic do_reset();
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    // Requester + one-cycle memory: records every grant into got_q. A
    // completed request is either reissued (next address) or dropped.
    task automatic collect_grants(input int sel, input int n, input int i_reloads, input int d_reloads);
        int     ir;
        int     dr;
        int     cyc;
        bit     drop_i;
        bit     drop_d;
        bit     reload_i;
        bit     reload_d;
        grant_t g;
        ir = i_reloads; dr = d_reloads; cyc = 0;
        drop_i = 0; drop_d = 0; reload_i = 0; reload_d = 0;
        while (got_q.size() < n && cyc < 40) begin
            @(posedge CLK); #1;
            cyc++;
            if (drop_i) iREN = 1'b0;
            if (drop_d) begin dREN = 1'b0; dWEN = 1'b0; end
            if (reload_i) iaddr = iaddr + 32'd4;
            if (reload_d) daddr = daddr + 32'd4;
            drop_i = 0; drop_d = 0; reload_i = 0; reload_d = 0;
            ram_ready = ramREN_v[sel] | ramWEN_v[sel];
            ramload   = 32'hC0DE_0000 + 32'(cyc);
            @(negedge CLK);
            sample(sel);
            if (obs_ren || obs_wen) begin
                g.instr = (obs_state == INSTR);
                g.ren   = obs_ren;
                g.wen   = obs_wen;
                g.addr  = obs_addr;
                g.store = obs_store;
                g.scnt  = obs_scnt;
                g.done  = g.instr ? ~obs_iwait : ~obs_dwait;
                got_q.push_back(g);
            end
            if (iREN && !obs_iwait) begin
                if (ir > 0) begin ir--; reload_i = 1; end else drop_i = 1;
            end
            if ((dREN || dWEN) && !obs_dwait) begin
                if (dr > 0) begin dr--; reload_d = 1; end else drop_d = 1;
            end
        end
        @(posedge CLK); #1;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
        iaddr = 32'h1234; daddr = 32'h5678; dstore = 32'h9; ramload = '0;
        @(posedge CLK); #1;
        @(negedge CLK);
        sample(0);
        n_cmp++; if (obs_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d required %0d", obs_state, IDLE); end
        n_cmp++; if (obs_scnt !== 4'd0) begin n_fail++; $display("FAIL reset_scnt: got %0d required 0", obs_scnt); end
        n_cmp++; if ({obs_ren, obs_wen} !== 2'b00) begin n_fail++; $display("FAIL reset_enables: got %b required 00", {obs_ren, obs_wen}); end
        n_cmp++; if ({obs_addr, obs_store} !== 64'd0) begin n_fail++; $display("FAIL reset_addr_store: got %h required 0", {obs_addr, obs_store}); end
        n_cmp++; if ({obs_iwait, obs_dwait} !== 2'b10) begin n_fail++; $display("FAIL reset_waits: got %b required 10", {obs_iwait, obs_dwait}); end
        // A stray ram_ready with nothing granted must not move the FSM.
        RST = 1'b0; iREN = 1'b0; ram_ready = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        sample(0);
        n_cmp++; if (obs_state !== IDLE || obs_ren !== 1'b0) begin n_fail++; $display("FAIL idle_ready_ignored: got state %0d ren %b required state 0 ren 0", obs_state, obs_ren); end
        ram_ready = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_single_fetch();
        do_reset();
        iREN = 1'b1; iaddr = 32'h40;
        @(posedge CLK); #1;
        for (int g = 1; g <= 3; g++) begin
            if (g == 3) begin ram_ready = 1'b1; ramload = 32'hDEADBEEF; end
            @(negedge CLK);
            sample(0);
            n_cmp++; if ({obs_ren, obs_wen, obs_addr} !== {2'b10, 32'h40}) begin n_fail++; $display("FAIL fetch_cmd_c%0d: got ren %b wen %b addr %h required 1 0 40", g, obs_ren, obs_wen, obs_addr); end
            n_cmp++; if (obs_iwait !== (g != 3)) begin n_fail++; $display("FAIL fetch_iwait_c%0d: got %b required %b", g, obs_iwait, (g != 3)); end
            if (g == 3) begin
                n_cmp++; if (obs_iload !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_iload: got %h required deadbeef", obs_iload); end
            end
            @(posedge CLK); #1;
            ram_ready = 1'b0;
        end
        iREN = 1'b0;
        @(negedge CLK);
        sample(0);
        n_cmp++; if (obs_state !== IDLE || obs_ren !== 1'b0) begin n_fail++; $display("FAIL fetch_idle_after: got state %0d ren %b required 0 0", obs_state, obs_ren); end
        @(posedge CLK); #1;
    endtask

    task automatic test_simultaneous();
        grant_t e;
        grant_t g;
        do_reset();
        iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h5;
        exp_q.push_back('{instr:1'b0, ren:1'b0, wen:1'b1, addr:32'h100, store:32'h5, scnt:4'd1, done:1'b1});
        exp_q.push_back('{instr:1'b1, ren:1'b1, wen:1'b0, addr:32'h80, store:32'h0, scnt:4'd0, done:1'b1});
        collect_grants(0, 2, 0, 0);
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL simul_count: got %0d grants required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL simul_grant: got %h required %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_starvation();
        grant_t e;
        grant_t g;
        do_reset();
        iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h200;
        exp_q.push_back('{instr:1'b0, ren:1'b1, wen:1'b0, addr:32'h200, store:32'h0, scnt:4'd1, done:1'b1});
        exp_q.push_back('{instr:1'b0, ren:1'b1, wen:1'b0, addr:32'h204, store:32'h0, scnt:4'd2, done:1'b1});
        exp_q.push_back('{instr:1'b1, ren:1'b1, wen:1'b0, addr:32'h300, store:32'h0, scnt:4'd0, done:1'b1});
        collect_grants(1, 3, 0, 10);
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL starve_count: got %0d grants required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL starve_grant: got %h required %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_instr_priority();
        grant_t e;
        grant_t g;
        do_reset();
        iREN = 1'b1; iaddr = 32'h400; dREN = 1'b1; daddr = 32'h500;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{instr:1'b1, ren:1'b1, wen:1'b0, addr:32'h400 + 32'(4 * k), store:32'h0, scnt:4'd0, done:1'b1});
        end
        exp_q.push_back('{instr:1'b0, ren:1'b1, wen:1'b0, addr:32'h500, store:32'h0, scnt:4'd0, done:1'b1});
        collect_grants(2, 4, 2, 0);
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL prio_count: got %0d grants required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL prio_grant: got %h required %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_abort();
        do_reset();
        dREN = 1'b1; daddr = 32'h600;
        @(posedge CLK); #1;
        @(negedge CLK);
        sample(0);
        n_cmp++; if (obs_state !== DATA || obs_ren !== 1'b1) begin n_fail++; $display("FAIL abort_granted: got state %0d ren %b required 2 1", obs_state, obs_ren); end
        @(posedge CLK); #1;
        dREN = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        sample(0);
        n_cmp++; if (obs_state !== IDLE) begin n_fail++; $display("FAIL abort_state: got %0d required 0", obs_state); end
        n_cmp++; if ({obs_ren, obs_wen} !== 2'b00) begin n_fail++; $display("FAIL abort_enables: got %b required 00", {obs_ren, obs_wen}); end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        iREN = 1'b1; iaddr = 32'h700;
        @(posedge CLK); #1;
        @(negedge CLK);
        sample(0);
        n_cmp++; if (obs_state !== INSTR || obs_ren !== 1'b1) begin n_fail++; $display("FAIL rstmid_granted: got state %0d ren %b required 1 1", obs_state, obs_ren); end
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        sample(0);
        n_cmp++; if (obs_state !== IDLE || obs_scnt !== 4'd0) begin n_fail++; $display("FAIL rstmid_state: got state %0d scnt %0d required 0 0", obs_state, obs_scnt); end
        n_cmp++; if ({obs_ren, obs_wen, obs_addr} !== 34'd0) begin n_fail++; $display("FAIL rstmid_cmd: got ren %b wen %b addr %h required all 0", obs_ren, obs_wen, obs_addr); end
        n_cmp++; if (obs_iwait !== 1'b1) begin n_fail++; $display("FAIL rstmid_iwait: got %b required 1", obs_iwait); end
        iREN = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_both_rw();
        grant_t e;
        grant_t g;
        do_reset();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h800; dstore = 32'h77;
        exp_q.push_back('{instr:1'b0, ren:1'b0, wen:1'b1, addr:32'h800, store:32'h77, scnt:4'd0, done:1'b1});
        collect_grants(0, 1, 0, 0);
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rw_count: got %0d grants required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL rw_grant: got %h required %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_instr_priority();
        test_abort();
        test_reset_mid_access();
        test_both_rw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
